// File: rtl/fc_agu_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : fc_agu_gen_if
// Description : Address beat bus from the FC AGU to the PE array buffers.
// Revision    : 1.0 - initial release
// ============================================================================
interface fc_agu_gen_if #(
    parameter int ADDR_W = 8,
    parameter int BATCH  = 4
);
    localparam int SEL_W = (BATCH > 1) ? $clog2(BATCH) : 1;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] dbuf_addr;
    logic              dbuf_mask;
    logic [1:0]        dbuf_mux;
    logic [ADDR_W-1:0] pbuf_addr;
    logic [SEL_W-1:0]  pbuf_sel;
    logic [ADDR_W-1:0] abuf_addr;
    logic [BATCH-1:0]  abuf_acc_en;
    logic              abuf_acc_new;

    modport master (
        output out_valid, dbuf_addr, dbuf_mask, dbuf_mux, pbuf_addr,
               pbuf_sel, abuf_addr, abuf_acc_en, abuf_acc_new,
        input  out_ready
    );

    modport slave (
        input  out_valid, dbuf_addr, dbuf_mask, dbuf_mux, pbuf_addr,
               pbuf_sel, abuf_addr, abuf_acc_en, abuf_acc_new,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fc_agu_gen.sv
`default_nettype none
// ============================================================================
// Module      : fc_agu_gen
// Description : FC-layer address generator; walks an (idx, trip) loop nest
//               and emits one registered buffer-address beat per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_agu_gen #(
    parameter int ADDR_W = 8,
    parameter int BATCH  = 4,
    parameter int CNT_W  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    output logic                   busy,
    output logic                   done,
    input  wire logic [1:0]        conf_mode,
    input  wire logic [CNT_W-1:0]  conf_idx_cnt,
    input  wire logic [CNT_W-1:0]  conf_idx_valid,
    input  wire logic [CNT_W-1:0]  conf_trip_cnt,
    input  wire logic              conf_is_new,
    input  wire logic [ADDR_W-1:0] conf_dbuf_base,
    input  wire logic [ADDR_W-1:0] conf_pbuf_base,
    input  wire logic [ADDR_W-1:0] conf_abuf_base,
    fc_agu_gen_if.master           bus
);
    localparam int SEL_W = (BATCH > 1) ? $clog2(BATCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_FP = 2'd0;
    localparam logic [1:0] M_BP = 2'd1;
    localparam logic [1:0] M_WU = 2'd2;
    localparam logic [1:0] M_RSV = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_idx_cnt;
    logic [CNT_W-1:0]  r_idx_valid;
    logic [CNT_W-1:0]  r_trip_cnt;
    logic              r_is_new;
    logic [ADDR_W-1:0] r_dbase;
    logic [ADDR_W-1:0] r_pbase;
    logic [ADDR_W-1:0] r_abase;
    logic [CNT_W-1:0]  r_i;
    logic [CNT_W-1:0]  r_t;
    logic [ADDR_W-1:0] r_lin;

    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic [ADDR_W-1:0] r_dbuf_addr;
    logic              r_dbuf_mask;
    logic [1:0]        r_dbuf_mux;
    logic [ADDR_W-1:0] r_pbuf_addr;
    logic [SEL_W-1:0]  r_pbuf_sel;
    logic [ADDR_W-1:0] r_abuf_addr;
    logic [BATCH-1:0]  r_acc_en;
    logic              r_acc_new;

    logic              w_accept;
    logic              w_t_wrap;
    logic              w_last;
    logic              w_zero_job;
    logic [CNT_W-1:0]  w_i_nxt;
    logic [CNT_W-1:0]  w_t_nxt;
    logic [ADDR_W-1:0] w_lin_nxt;

    logic [1:0]        w_bmode;
    logic [CNT_W-1:0]  w_bi;
    logic [CNT_W-1:0]  w_bt;
    logic [ADDR_W-1:0] w_blin;
    logic [CNT_W-1:0]  w_bvalid;
    logic              w_bnew;
    logic [ADDR_W-1:0] w_bdb;
    logic [ADDR_W-1:0] w_bpb;
    logic [ADDR_W-1:0] w_bab;

    logic [ADDR_W-1:0] w_i_a;
    logic [ADDR_W-1:0] w_t_a;
    logic [SEL_W-1:0]  w_sel;
    logic [BATCH-1:0]  w_one_hot;

    logic [ADDR_W-1:0] w_dbuf_addr;
    logic              w_dbuf_mask;
    logic [1:0]        w_dbuf_mux;
    logic [ADDR_W-1:0] w_pbuf_addr;
    logic [SEL_W-1:0]  w_pbuf_sel;
    logic [ADDR_W-1:0] w_abuf_addr;
    logic [BATCH-1:0]  w_acc_en;
    logic              w_acc_new;

    assign w_accept   = r_valid & bus.out_ready;
    assign w_t_wrap   = (r_t == r_trip_cnt - CNT_W'(1));
    assign w_last     = w_t_wrap && (r_i == r_idx_cnt - CNT_W'(1));
    assign w_t_nxt    = w_t_wrap ? '0 : r_t + CNT_W'(1);
    assign w_i_nxt    = w_t_wrap ? r_i + CNT_W'(1) : r_i;
    assign w_lin_nxt  = r_lin + ADDR_W'(1);
    assign w_zero_job = (conf_idx_cnt == '0) || (conf_trip_cnt == '0) || (conf_mode == M_RSV);

    // Outputs are registered, so the beat loaded at a clock edge is computed
    // from the counter values that will be current after that edge.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_bmode  = conf_mode;
            w_bi     = '0;
            w_bt     = '0;
            w_blin   = '0;
            w_bvalid = conf_idx_valid;
            w_bnew   = conf_is_new;
            w_bdb    = conf_dbuf_base;
            w_bpb    = conf_pbuf_base;
            w_bab    = conf_abuf_base;
        end else begin
            w_bmode  = r_mode;
            w_bi     = w_i_nxt;
            w_bt     = w_t_nxt;
            w_blin   = w_lin_nxt;
            w_bvalid = r_idx_valid;
            w_bnew   = r_is_new;
            w_bdb    = r_dbase;
            w_bpb    = r_pbase;
            w_bab    = r_abase;
        end
    end

    assign w_i_a     = ADDR_W'(w_bi);
    assign w_t_a     = ADDR_W'(w_bt);
    assign w_sel     = w_bt[SEL_W-1:0];
    assign w_one_hot = {{(BATCH-1){1'b0}}, 1'b1} << w_sel;

    always_comb begin
        w_dbuf_addr = '0;
        w_dbuf_mask = (w_bi >= w_bvalid);
        w_dbuf_mux  = '0;
        w_pbuf_addr = '0;
        w_pbuf_sel  = '0;
        w_abuf_addr = '0;
        w_acc_en    = '0;
        w_acc_new   = 1'b0;
        case (w_bmode)
            M_FP: begin
                w_dbuf_addr = w_bdb + w_i_a;
                w_pbuf_addr = w_bpb + w_blin;
                w_abuf_addr = w_bab + w_t_a;
                w_dbuf_mux  = w_bi[1:0];
                w_acc_en    = '1;
                w_acc_new   = w_bnew & (w_bi == '0);
            end
            M_BP: begin
                w_dbuf_addr = w_bdb + w_t_a;
                w_pbuf_addr = w_bpb + w_blin;
                w_abuf_addr = w_bab + w_i_a;
                w_acc_en    = '1;
                w_acc_new   = w_bnew & (w_bt == '0);
            end
            M_WU: begin
                w_dbuf_addr = w_bdb + w_i_a;
                w_pbuf_addr = w_bpb + w_t_a;
                w_abuf_addr = w_bab + w_blin;
                w_pbuf_sel  = w_sel;
                w_acc_en    = w_one_hot;
                w_acc_new   = w_bnew;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_idx_cnt   <= '0;
            r_idx_valid <= '0;
            r_trip_cnt  <= '0;
            r_is_new    <= 1'b0;
            r_dbase     <= '0;
            r_pbase     <= '0;
            r_abase     <= '0;
            r_i         <= '0;
            r_t         <= '0;
            r_lin       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_dbuf_addr <= '0;
            r_dbuf_mask <= 1'b0;
            r_dbuf_mux  <= '0;
            r_pbuf_addr <= '0;
            r_pbuf_sel  <= '0;
            r_abuf_addr <= '0;
            r_acc_en    <= '0;
            r_acc_new   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode      <= conf_mode;
                        r_idx_cnt   <= conf_idx_cnt;
                        r_idx_valid <= conf_idx_valid;
                        r_trip_cnt  <= conf_trip_cnt;
                        r_is_new    <= conf_is_new;
                        r_dbase     <= conf_dbuf_base;
                        r_pbase     <= conf_pbuf_base;
                        r_abase     <= conf_abuf_base;
                        r_i         <= '0;
                        r_t         <= '0;
                        r_lin       <= '0;
                        r_busy      <= 1'b1;
                        if (w_zero_job) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            r_valid     <= 1'b1;
                            r_dbuf_addr <= w_dbuf_addr;
                            r_dbuf_mask <= w_dbuf_mask;
                            r_dbuf_mux  <= w_dbuf_mux;
                            r_pbuf_addr <= w_pbuf_addr;
                            r_pbuf_sel  <= w_pbuf_sel;
                            r_abuf_addr <= w_abuf_addr;
                            r_acc_en    <= w_acc_en;
                            r_acc_new   <= w_acc_new;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_i         <= w_i_nxt;
                            r_t         <= w_t_nxt;
                            r_lin       <= w_lin_nxt;
                            r_dbuf_addr <= w_dbuf_addr;
                            r_dbuf_mask <= w_dbuf_mask;
                            r_dbuf_mux  <= w_dbuf_mux;
                            r_pbuf_addr <= w_pbuf_addr;
                            r_pbuf_sel  <= w_pbuf_sel;
                            r_abuf_addr <= w_abuf_addr;
                            r_acc_en    <= w_acc_en;
                            r_acc_new   <= w_acc_new;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign bus.out_valid    = r_valid;
    assign bus.dbuf_addr    = r_dbuf_addr;
    assign bus.dbuf_mask    = r_dbuf_mask;
    assign bus.dbuf_mux     = r_dbuf_mux;
    assign bus.pbuf_addr    = r_pbuf_addr;
    assign bus.pbuf_sel     = r_pbuf_sel;
    assign bus.abuf_addr    = r_abuf_addr;
    assign bus.abuf_acc_en  = r_acc_en;
    assign bus.abuf_acc_new = r_acc_new;
endmodule
`default_nettype wire

// File: tb/tb_fc_agu_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_agu_gen
// Description : Scoreboard bench for fc_agu_gen with directed job sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_agu_gen;
    // {dbuf, pbuf, abuf, mask, mux, sel, acc_en, acc_new}
    typedef logic [33:0] beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] conf_mode;
    logic [7:0] conf_idx_cnt;
    logic [7:0] conf_idx_valid;
    logic [7:0] conf_trip_cnt;
    logic       conf_is_new;
    logic [7:0] conf_dbuf_base;
    logic [7:0] conf_pbuf_base;
    logic [7:0] conf_abuf_base;

    fc_agu_gen_if #(.ADDR_W(8), .BATCH(4)) bus ();

    fc_agu_gen #(.ADDR_W(8), .BATCH(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .conf_mode      (conf_mode),
        .conf_idx_cnt   (conf_idx_cnt),
        .conf_idx_valid (conf_idx_valid),
        .conf_trip_cnt  (conf_trip_cnt),
        .conf_is_new    (conf_is_new),
        .conf_dbuf_base (conf_dbuf_base),
        .conf_pbuf_base (conf_pbuf_base),
        .conf_abuf_base (conf_abuf_base),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    acc_cnt = 0;
    int    stall_cnt = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    beat_t q[$];
    beat_t obs;

    assign obs = {bus.dbuf_addr, bus.pbuf_addr, bus.abuf_addr, bus.dbuf_mask,
                  bus.dbuf_mux, bus.pbuf_sel, bus.abuf_acc_en, bus.abuf_acc_new};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Every presented beat is checked against the queue head, so a stalled
    // beat is checked once per cycle it is held.
    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("beat", obs, q[0]);
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        acc_cnt++;
                    end else begin
                        stall_cnt++;
                    end
                end
            end
        end
    end

    task automatic push_job(input logic [1:0] mode, input logic [7:0] idx, vld, trip,
                            input logic nw, input logic [7:0] db, pb, ab);
        logic [7:0] lin;
        logic [7:0] d, p, a;
        logic [1:0] mux, sel;
        logic [3:0] en;
        logic       an;
        lin = 8'h00;
        if (idx == 0 || trip == 0 || mode == 2'd3) return;
        for (int i = 0; i < int'(idx); i++) begin
            for (int t = 0; t < int'(trip); t++) begin
                mux = 2'b00;
                sel = 2'b00;
                en  = 4'b1111;
                case (mode)
                    2'd0: begin
                        d = db + 8'(i); p = pb + lin; a = ab + 8'(t);
                        mux = 2'(i); an = nw && (i == 0);
                    end
                    2'd1: begin
                        d = db + 8'(t); p = pb + lin; a = ab + 8'(i);
                        an = nw && (t == 0);
                    end
                    default: begin
                        d = db + 8'(i); p = pb + 8'(t); a = ab + lin;
                        sel = 2'(t % 4); en = 4'b0001 << sel; an = nw;
                    end
                endcase
                q.push_back({d, p, a, (8'(i) >= vld), mux, sel, en, an});
                lin = lin + 8'h01;
            end
        end
    endtask

    task automatic run_job(input logic [1:0] mode, input logic [7:0] idx, vld, trip,
                           input logic nw, input logic [7:0] db, pb, ab,
                           input int stall_beat, input int stall_len,
                           input bit rnd, input bit poke);
        int s, n, acc0, st0, dn0, stalled;
        bit got;
        conf_mode = mode; conf_idx_cnt = idx; conf_idx_valid = vld;
        conf_trip_cnt = trip; conf_is_new = nw;
        conf_dbuf_base = db; conf_pbuf_base = pb; conf_abuf_base = ab;
        q.delete();
        push_job(mode, idx, vld, trip, nw, db, pb, ab);
        n = q.size();
        acc0 = acc_cnt; st0 = stall_cnt; dn0 = done_cnt; stalled = 0;
        chk("busy_before_start", busy, 0);
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the config to prove the DUT latched it at start.
        conf_dbuf_base = ~db; conf_pbuf_base = ~pb; conf_abuf_base = ~ab;
        conf_mode = mode ^ 2'b01; conf_idx_cnt = idx + 8'd3;
        conf_trip_cnt = trip + 8'd1; conf_is_new = ~nw; conf_idx_valid = 8'd0;
        chk("busy_after_start", busy, 1);
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
            else if ((acc_cnt - acc0) == stall_beat && stalled < stall_len) begin
                bus.out_ready = 1'b0;
                stalled++;
            end else bus.out_ready = 1'b1;
            start = poke && (k == 1);
            @(posedge clk); #1;
            if (done_cnt != dn0) got = 1'b1;
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
        chk("done_seen", got, 1);
        chk("done_count", done_cnt - dn0, 1);
        chk("done_cycle", done_cyc - s, n + (stall_cnt - st0) + 1);
        chk("beats_accepted", acc_cnt - acc0, n);
        chk("queue_drained", q.size(), 0);
        chk("busy_after_done", busy, 0);
        q.delete();
    endtask

    initial begin
        int acc0, dn0;
        bit hit;
        rst = 1'b0; start = 1'b0; bus.out_ready = 1'b1;
        conf_mode = 2'd0; conf_idx_cnt = 8'd0; conf_idx_valid = 8'd0;
        conf_trip_cnt = 8'd0; conf_is_new = 1'b0;
        conf_dbuf_base = 8'd0; conf_pbuf_base = 8'd0; conf_abuf_base = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, bus.out_valid, obs}, 37'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // FP reference job, then WU lane rotation, then start ignored mid-run
        run_job(2'd0, 8'd2, 8'd2, 8'd3, 1'b1, 8'h10, 8'h20, 8'h30, -1, 0, 1'b0, 1'b0);
        run_job(2'd2, 8'd1, 8'd1, 8'd6, 1'b0, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0, 1'b0);
        run_job(2'd2, 8'd2, 8'd1, 8'd5, 1'b1, 8'h05, 8'h40, 8'hFD, -1, 0, 1'b0, 1'b1);
        // Back-pressure on beat 2
        run_job(2'd0, 8'd2, 8'd2, 8'd3, 1'b1, 8'h10, 8'h20, 8'h30, 2, 3, 1'b0, 1'b0);
        // Padding mask with pbuf wrap
        run_job(2'd1, 8'd3, 8'd2, 8'd2, 1'b1, 8'h40, 8'hFE, 8'h80, -1, 0, 1'b0, 1'b0);
        // Zero-beat jobs
        run_job(2'd0, 8'd0, 8'd0, 8'd3, 1'b0, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0, 1'b0);
        run_job(2'd3, 8'd2, 8'd2, 8'd3, 1'b0, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0, 1'b0);
        run_job(2'd1, 8'd2, 8'd2, 8'd0, 1'b0, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0, 1'b0);
        // Random back-pressure with address wrap
        run_job(2'd0, 8'd5, 8'd3, 8'd4, 1'b1, 8'hFE, 8'hFA, 8'hFF, -1, 0, 1'b1, 1'b0);

        // Reset in the middle of a 6-beat job
        conf_mode = 2'd0; conf_idx_cnt = 8'd2; conf_idx_valid = 8'd1;
        conf_trip_cnt = 8'd3; conf_is_new = 1'b1;
        conf_dbuf_base = 8'h50; conf_pbuf_base = 8'h60; conf_abuf_base = 8'h70;
        q.delete();
        push_job(2'd0, 8'd2, 8'd1, 8'd3, 1'b1, 8'h50, 8'h60, 8'h70);
        acc0 = acc_cnt; dn0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            if ((acc_cnt - acc0) == 3) hit = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("reached_beat3", hit, 1);
        rst = 1'b0;
        #1;
        chk("reset_mid_outputs", {busy, done, bus.out_valid, obs}, 37'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_cnt - dn0, 0);
        chk("idle_after_reset", {busy, bus.out_valid}, 2'b00);
        run_job(2'd0, 8'd2, 8'd1, 8'd3, 1'b1, 8'h50, 8'h60, 8'h70, -1, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/fc_agu_gen.md
# fc_agu_gen

Parametrised address generation unit for fully-connected layers, successor to the fixed-function FC AGU. It sits between the layer controller and the PE array's data, parameter and accumulate buffers. For one job it walks an (idx, trip) loop nest and emits one address beat per cycle. It supports forward (FP), backward (BP) and weight-update (WU) modes, padding masks and per-batch accumulate selection, with valid/ready back-pressure toward the buffers.

## Interface
- ADDR_W, 8, width of all buffer addresses
- BATCH, 4, batch lanes, power of two ≥ 2
- CNT_W, 8, width of idx/trip counters
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  job start pulse, sampled only in IDLE
- busy  out  1  high while state ≠ IDLE
- done  out  1  one-cycle pulse at job end
- conf_mode  in  2  0=FP, 1=BP, 2=WU, 3=reserved
- conf_idx_cnt  in  CNT_W  outer loop count (idx)
- conf_idx_valid  in  CNT_W  idx values ≥ this are padding
- conf_trip_cnt  in  CNT_W  inner loop count per idx
- conf_is_new  in  1  first write to accumulate buffer overwrites rather than accumulates
- conf_dbuf_base / conf_pbuf_base / conf_abuf_base  in  ADDR_W each  base addresses
- out_valid  out  1  address beat valid
- out_ready  in  1  consumer accepts beat
- dbuf_addr  out  ADDR_W  data buffer address
- dbuf_mask  out  1  padding mask, 1 = feed zero
- dbuf_mux  out  2  data sharing mux select
- pbuf_addr  out  ADDR_W  parameter buffer address
- pbuf_sel  out  bw(BATCH)  parameter scalar select
- abuf_addr  out  ADDR_W  accumulate buffer address
- abuf_acc_en  out  BATCH  per-lane accumulate enable
- abuf_acc_new  out  1  overwrite instead of accumulate

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE + start: latch all conf_* inputs, clear i, t and the linear counter lin, go to RUN.
  - If conf_idx_cnt = 0, conf_trip_cnt = 0 or mode 3: go straight to DONE with no beats.
- RUN: beat (i,t) is presented; a beat advances on out_valid & out_ready.
  - Advance: t++ and lin++. When t = trip_cnt−1, set t=0 and i++.
  - After beat (idx_cnt−1, trip_cnt−1) is accepted, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in RUN and DONE.
- Common to all modes: dbuf_mask = (i ≥ idx_valid).
- FP:
  - dbuf_addr = dbuf_base+i; pbuf_addr = pbuf_base+lin; abuf_addr = abuf_base+t
  - dbuf_mux = i[1:0]; pbuf_sel = 0; acc_en = all ones; acc_new = is_new & (i==0)
- BP:
  - dbuf_addr = dbuf_base+t; pbuf_addr = pbuf_base+lin; abuf_addr = abuf_base+i
  - dbuf_mux = 0; pbuf_sel = 0; acc_en = all ones; acc_new = is_new & (t==0)
- WU:
  - dbuf_addr = dbuf_base+i; pbuf_addr = pbuf_base+t; abuf_addr = abuf_base+lin
  - dbuf_mux = 0; pbuf_sel = t mod BATCH; acc_en = one-hot(pbuf_sel); acc_new = is_new
- Arithmetic: all address sums are modulo 2^ADDR_W, so addresses wrap silently. lin is ADDR_W bits wide and wraps.
- Reset values (asserted at any time, including mid-job): state IDLE; busy, done and out_valid 0; all address, mux, sel, acc_en and acc_new outputs 0. The job is abandoned and there is no done pulse.

## Timing
- All outputs are registered.
- First out_valid appears the cycle after start is sampled.
- With out_ready held high, an N = idx_cnt·trip_cnt job is valid for N consecutive cycles. done is asserted in cycle N+1 after the start cycle (counting from 1).
- While out_valid & !out_ready: all beat outputs are held stable and the counters are frozen.
- out_valid may not depend combinationally on out_ready.
- Zero-beat job: done pulses the cycle after start; out_valid stays 0.
- busy rises the cycle after start and falls the cycle after done.
- A new start is accepted in the cycle busy=0, i.e. back-to-back jobs have at most one idle cycle.

## Test plan
- FP: idx_cnt=2, trip=3, idx_valid=2, bases 0x10/0x20/0x30, is_new=1, ready=1 -> dbuf 10,10,10,11,11,11; pbuf 20..25; abuf 30,31,32,30,31,32; acc_new 1,1,1,0,0,0; mux 0,0,0,1,1,1; done in cycle 7.
- WU: BATCH=4, idx_cnt=1, trip=6, bases 0 -> pbuf_sel 0,1,2,3,0,1; acc_en 0001,0010,0100,1000,0001,0010; abuf 0..5.
- Back-pressure: FP job as above with ready low for 3 cycles while beat 2 is presented -> beat 2 held unchanged for 4 cycles, no beat skipped or duplicated, done in cycle 10.
- Padding and wrap: BP, idx_cnt=3, idx_valid=2, trip=2, pbuf_base=0xFE -> mask 0,0,0,0,1,1; pbuf FE,FF,00,01,02,03.
- Zero job and mode 3: idx_cnt=0, then mode=3 -> done one cycle after each start, out_valid never 1.
- Reset mid-job: drive rst low at beat 3 of a 6-beat job -> all outputs 0 immediately, no done pulse; a following start runs a clean full job.
